parking_lot_controller: RTL and testbench

- Central controller for a multi-gate parking lot. Each gate has its own occupancy-detector FSM, which emits one-cycle o_car_enter / o_car_exit pulses.
- The block arbitrates entry requests from N_GATES gates for the shared pool of free spaces. It reserves a space per granted gate and drives each gate's barrier.
- It holds the authoritative occupancy count, with full/empty status and sticky error flags.

---
 rtl/plc_pkg.sv | 20 ++
 rtl/plc_rr_arbiter.sv | 46 ++++
 rtl/parking_lot_controller.sv | 175 +++++++++++++++++
 tb/tb_parking_lot_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/plc_pkg.sv
// Shared types, default sizing and helpers for the parking lot controller.
package plc_pkg;

  typedef enum logic {e_gate_idle, e_gate_grant} t_gate_state;

  localparam int unsigned PLC_N_GATES     = 2;
  localparam int unsigned PLC_CAPACITY    = 16;
  localparam int unsigned PLC_TIMEOUT_CYC = 1000;

  // Callers zero-extend their vector to 32 bits, so at most 32 gates are supported.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      c += {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/plc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, rotating pointer advances only on a grant.
module plc_rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  input  logic         i_en,
  output logic [N-1:0] o_gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int unsigned   win;
  int unsigned   idx;

  always_comb begin
    o_gnt = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    win   = 0;
    idx   = 0;
    // Scan starting at the pointer so the most recent winner has lowest priority.
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_q) + i) % N;
      if (!found && i_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (i_en && found) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (j == win) o_gnt[j] = 1'b1;
      end
      ptr_d = PW'((win + 1) % N);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/parking_lot_controller.sv
// Multi-gate parking lot controller: space reservation, barrier control, occupancy.
// Optional lifetime statistics outputs are enabled by defining PLC_STATS_EN.
module parking_lot_controller
  import plc_pkg::*;
#(
  parameter int unsigned N_GATES     = PLC_N_GATES,
  parameter int unsigned CAPACITY    = PLC_CAPACITY,
  parameter int unsigned CNT_W       = $clog2(CAPACITY + 1),
  parameter int unsigned TIMEOUT_CYC = PLC_TIMEOUT_CYC
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_GATES-1:0] i_entry_req,
  input  logic [N_GATES-1:0] i_car_enter,
  input  logic [N_GATES-1:0] i_car_exit,
  output logic [N_GATES-1:0] o_gate_open,
  output logic [CNT_W-1:0]   o_occupancy,
  output logic [CNT_W-1:0]   o_reserved,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_err_underflow,
  output logic               o_err_overflow
`ifdef PLC_STATS_EN
  ,
  output logic [15:0]        o_total_entries,
  output logic [15:0]        o_total_exits,
  output logic [7:0]         o_timeouts
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam int unsigned SW = CNT_W + $clog2(N_GATES) + 1;

  t_gate_state        gate_q [N_GATES];
  t_gate_state        gate_d [N_GATES];
  logic [TW-1:0]      tmr_q  [N_GATES];
  logic [TW-1:0]      tmr_d  [N_GATES];
  logic [CNT_W-1:0]   occ_q, occ_d, res_q, res_d;
  logic               unf_q, unf_d, ovf_q, ovf_d;

  logic [N_GATES-1:0] idle_req, gnt, rel, tmo;
  logic [CNT_W:0]     load;
  logic               free_ok;
  int unsigned        e_cnt, x_cnt, rel_cnt;
  logic signed [SW-1:0] occ_calc;

  // Free space is judged on registered counts only; tailgating may push load past CAPACITY.
  assign load    = {1'b0, occ_q} + {1'b0, res_q};
  assign free_ok = load < (CNT_W + 1)'(CAPACITY);

  always_comb begin
    for (int unsigned g = 0; g < N_GATES; g++) begin
      idle_req[g] = i_entry_req[g] && (gate_q[g] == e_gate_idle);
    end
  end

  plc_rr_arbiter #(.N(N_GATES)) u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req (idle_req),
    .i_en  (free_ok),
    .o_gnt (gnt)
  );

  always_comb begin
    rel = '0;
    tmo = '0;
    for (int unsigned g = 0; g < N_GATES; g++) begin
      gate_d[g] = gate_q[g];
      tmr_d[g]  = '0;
      case (gate_q[g])
        e_gate_idle: begin
          if (gnt[g]) gate_d[g] = e_gate_grant;
        end
        e_gate_grant: begin
          if (i_car_enter[g]) begin
            gate_d[g] = e_gate_idle;
            rel[g]    = 1'b1;
          end else if (tmr_q[g] == TW'(TIMEOUT_CYC - 1)) begin
            gate_d[g] = e_gate_idle;
            rel[g]    = 1'b1;
            tmo[g]    = 1'b1;
          end else begin
            tmr_d[g] = tmr_q[g] + 1'b1;
          end
        end
        default: gate_d[g] = e_gate_idle;
      endcase
    end
  end

  always_comb begin
    e_cnt    = popcount(32'(i_car_enter));
    x_cnt    = popcount(32'(i_car_exit));
    rel_cnt  = popcount(32'(rel));
    res_d    = res_q + CNT_W'(|gnt) - CNT_W'(rel_cnt);
    unf_d    = unf_q;
    ovf_d    = ovf_q;
    occ_calc = $signed(SW'(occ_q)) + $signed(SW'(e_cnt)) - $signed(SW'(x_cnt));
    if (occ_calc < 0) begin
      occ_d = '0;
      unf_d = 1'b1;
    end else if (occ_calc > $signed(SW'(CAPACITY))) begin
      occ_d = CNT_W'(CAPACITY);
      ovf_d = 1'b1;
    end else begin
      occ_d = occ_calc[CNT_W-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned g = 0; g < N_GATES; g++) begin
        gate_q[g] <= e_gate_idle;
        tmr_q[g]  <= '0;
      end
      occ_q <= '0;
      res_q <= '0;
      unf_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      for (int unsigned g = 0; g < N_GATES; g++) begin
        gate_q[g] <= gate_d[g];
        tmr_q[g]  <= tmr_d[g];
      end
      occ_q <= occ_d;
      res_q <= res_d;
      unf_q <= unf_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    for (int unsigned g = 0; g < N_GATES; g++) begin
      o_gate_open[g] = (gate_q[g] == e_gate_grant);
    end
  end

  assign o_occupancy     = occ_q;
  assign o_reserved      = res_q;
  assign o_full          = !free_ok;
  assign o_empty         = (occ_q == '0);
  assign o_err_underflow = unf_q;
  assign o_err_overflow  = ovf_q;

`ifdef PLC_STATS_EN
  logic [15:0] entries_q, entries_d, exits_q, exits_d;
  logic [7:0]  timeouts_q, timeouts_d;
  logic [8:0]  tmo_sum;

  always_comb begin
    entries_d  = entries_q + 16'(e_cnt);
    exits_d    = exits_q + 16'(x_cnt);
    tmo_sum    = {1'b0, timeouts_q} + 9'(popcount(32'(tmo)));
    timeouts_d = (tmo_sum > 9'd255) ? 8'd255 : tmo_sum[7:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      entries_q  <= '0;
      exits_q    <= '0;
      timeouts_q <= '0;
    end else begin
      entries_q  <= entries_d;
      exits_q    <= exits_d;
      timeouts_q <= timeouts_d;
    end
  end

  assign o_total_entries = entries_q;
  assign o_total_exits   = exits_q;
  assign o_timeouts      = timeouts_q;
`endif

endmodule

// File: tb/tb_parking_lot_controller.sv
// Directed self-checking bench for parking_lot_controller (2 gates, 16 spaces).
module tb_parking_lot_controller;

  localparam int unsigned NG  = 2;
  localparam int unsigned CAP = 16;
  localparam int unsigned TMO = 10;
  localparam int unsigned CW  = 5;

  logic          clk;
  logic          rst;
  logic [NG-1:0] req, enter, exitp;
  logic [NG-1:0] gate_open;
  logic [CW-1:0] occ, res;
  logic          full, empty, unf, ovf;
`ifdef PLC_STATS_EN
  logic [15:0]   tot_ent, tot_ext;
  logic [7:0]    tmo_cnt;
`endif

  int total = 0;
  int bad   = 0;

  parking_lot_controller #(
    .N_GATES     (NG),
    .CAPACITY    (CAP),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_entry_req     (req),
    .i_car_enter     (enter),
    .i_car_exit      (exitp),
    .o_gate_open     (gate_open),
    .o_occupancy     (occ),
    .o_reserved      (res),
    .o_full          (full),
    .o_empty         (empty),
    .o_err_underflow (unf),
    .o_err_overflow  (ovf)
`ifdef PLC_STATS_EN
    ,
    .o_total_entries (tot_ent),
    .o_total_exits   (tot_ext),
    .o_timeouts      (tmo_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; enter = '0; exitp = '0;
    repeat (3) tick();
    chk("rst_occ", 32'(occ), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_open", 32'(gate_open), 0);
    chk("rst_res", 32'(res), 0);
    chk("rst_errs", {30'b0, unf, ovf}, 0);
    rst = 1'b0;
    tick();
    chk("idle_occ", 32'(occ), 0);

    // basic entry on gate 0
    req = 2'b01; tick();
    chk("basic_open", 32'(gate_open), 2'b01);
    chk("basic_res", 32'(res), 1);
    req = 2'b00; enter = 2'b01; tick();
    enter = 2'b00;
    chk("basic_close", 32'(gate_open), 0);
    chk("basic_occ", 32'(occ), 1);
    chk("basic_res0", 32'(res), 0);
    chk("basic_empty", 32'(empty), 0);

    // single entry on gate 1 brings the pointer back to gate 0
    req = 2'b10; tick();
    chk("g1_open", 32'(gate_open), 2'b10);
    req = 2'b00; enter = 2'b10; tick();
    enter = 2'b00;
    chk("g1_occ", 32'(occ), 2);

    // round robin, pointer at gate 0
    req = 2'b11; tick();
    chk("rr1_first", 32'(gate_open), 2'b01);
    chk("rr1_res1", 32'(res), 1);
    tick();
    chk("rr1_second", 32'(gate_open), 2'b11);
    chk("rr1_res2", 32'(res), 2);
    req = 2'b00; enter = 2'b11; tick();
    enter = 2'b00;
    chk("rr1_close", 32'(gate_open), 0);
    chk("rr1_occ", 32'(occ), 4);

    // gate 0 alone, then both: gate 1 must now win first
    req = 2'b01; tick();
    req = 2'b00; enter = 2'b01; tick();
    enter = 2'b00;
    chk("g0_occ", 32'(occ), 5);
    req = 2'b11; tick();
    chk("rr2_first", 32'(gate_open), 2'b10);
    tick();
    chk("rr2_second", 32'(gate_open), 2'b11);
    req = 2'b00; enter = 2'b11; tick();
    enter = 2'b00;
    chk("rr2_occ", 32'(occ), 7);

    // tailgating enters at idle gates fill the lot to 15
    enter = 2'b11; repeat (4) tick();
    enter = 2'b00;
    chk("tail_occ", 32'(occ), 15);
    chk("tail_full", 32'(full), 0);
    chk("tail_res", 32'(res), 0);

    // one space left: exactly one grant (gate 1, pointer at 1)
    req = 2'b11; tick();
    chk("full_one", 32'(gate_open), 2'b10);
    chk("full_flag", 32'(full), 1);
    chk("full_res", 32'(res), 1);
    tick();
    chk("full_hold", 32'(gate_open), 2'b10);
    exitp = 2'b01; tick();
    exitp = 2'b00;
    chk("full_exit_occ", 32'(occ), 14);
    chk("full_exit_open", 32'(gate_open), 2'b10);
    chk("full_exit_flag", 32'(full), 0);
    tick();
    chk("full_late", 32'(gate_open), 2'b11);
    chk("full_late_res", 32'(res), 2);
    chk("full_late_flag", 32'(full), 1);
    req = 2'b00; enter = 2'b11; tick();
    enter = 2'b00;
    chk("cap_occ", 32'(occ), 16);
    chk("cap_res", 32'(res), 0);
    chk("cap_ovf", 32'(ovf), 0);
    chk("cap_full", 32'(full), 1);

    exitp = 2'b11; repeat (7) tick();
    exitp = 2'b00;
    chk("drain_occ", 32'(occ), 2);

    // timeout on gate 0
    req = 2'b01; tick();
    req = 2'b00;
    chk("tmo_open", 32'(gate_open), 2'b01);
    repeat (TMO - 1) tick();
    chk("tmo_last", 32'(gate_open), 2'b01);
    tick();
    chk("tmo_close", 32'(gate_open), 0);
    chk("tmo_res", 32'(res), 0);
    chk("tmo_occ", 32'(occ), 2);
`ifdef PLC_STATS_EN
    chk("tmo_count", 32'(tmo_cnt), 1);
`endif

    // simultaneous enter/exits, then underflow
    exitp = 2'b01; tick();
    chk("sim_pre", 32'(occ), 1);
    enter = 2'b01; exitp = 2'b11; tick();
    enter = 2'b00; exitp = 2'b00;
    chk("sim_occ", 32'(occ), 0);
    chk("sim_unf", 32'(unf), 0);
    chk("sim_empty", 32'(empty), 1);
    exitp = 2'b10; tick();
    exitp = 2'b00;
    chk("unf_occ", 32'(occ), 0);
    chk("unf_flag", 32'(unf), 1);
    tick();
    chk("unf_sticky", 32'(unf), 1);
`ifdef PLC_STATS_EN
    chk("stat_ent", 32'(tot_ent), 18);
    chk("stat_ext", 32'(tot_ext), 19);
`endif

    // asynchronous reset in the middle of a grant on gate 1
    req = 2'b10; tick();
    chk("mid_open", 32'(gate_open), 2'b10);
    #2 rst = 1'b1;
    #1;
    chk("async_open", 32'(gate_open), 0);
    chk("async_res", 32'(res), 0);
    chk("async_unf", 32'(unf), 0);
    chk("async_empty", 32'(empty), 1);
    req = 2'b01;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_open", 32'(gate_open), 2'b01);
    chk("post_rst_res", 32'(res), 1);

    // overflow saturation
    req = 2'b00; enter = 2'b01; tick();
    chk("ovf_pre", 32'(occ), 1);
    enter = 2'b11; repeat (7) tick();
    chk("ovf_15", 32'(occ), 15);
    chk("ovf_none", 32'(ovf), 0);
    tick();
    enter = 2'b00;
    chk("ovf_sat", 32'(occ), 16);
    chk("ovf_flag", 32'(ovf), 1);
    tick();
    chk("ovf_sticky", 32'(ovf), 1);
    chk("ovf_unf0", 32'(unf), 0);
`ifdef PLC_STATS_EN
    chk("stat_ent_r", 32'(tot_ent), 17);
    chk("stat_ext_r", 32'(tot_ext), 0);
    chk("stat_tmo_r", 32'(tmo_cnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
